// File: rtl/key_event_scheduler.sv
// Filters decoder key changes down to four game keys, queues press/release
// events, and generates timed auto-repeat events for a held direction key.
module key_event_scheduler #(
  parameter int           FIFO_DEPTH    = 4,
  parameter int           REPEAT_DELAY  = 25_000_000,
  parameter int           REPEAT_PERIOD = 5_000_000,
  parameter logic [8:0]   KEY_LEFT      = 9'h16B,
  parameter logic [8:0]   KEY_RIGHT     = 9'h174,
  parameter logic [8:0]   KEY_PAUSE     = 9'h029,
  parameter logic [8:0]   KEY_START     = 9'h05A
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic         evt_valid,
  output logic [3:0]   evt_data,
  input  logic         evt_ready,
  output logic [1:0]   move_dir,
  output logic         overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXC);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic [CW-1:0] C_DELAY  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] C_PERIOD = CW'(REPEAT_PERIOD - 1);

  // Index order doubles as the event id: 0=left, 1=right, 2=pause, 3=start.
  localparam logic [3:0][8:0] KEY_TABLE = {KEY_START, KEY_PAUSE, KEY_RIGHT, KEY_LEFT};

  logic [3:0]    r_held;
  logic [1:0]    r_state;
  logic          r_trk;
  logic [CW-1:0] r_cnt;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_overflow;
  logic [3:0]    r_mem [FIFO_DEPTH];

  logic [3:0] w_hit;
  logic [1:0] w_id;
  logic       w_press;
  logic       w_key_push;
  logic       w_is_dir;
  logic       w_dir_press;
  logic       w_trk_rel;
  logic       w_other_held;
  logic       w_expire;
  logic       w_rpt_push;
  logic       w_push;
  logic [3:0] w_push_data;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_wr_en;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_keymap
      assign w_hit[gi] = (last_change == KEY_TABLE[gi]);
    end
  endgenerate

  assign w_id         = {w_hit[3] | w_hit[2], w_hit[3] | w_hit[1]};
  assign w_press      = key_down[last_change];
  assign w_key_push   = key_valid && (|w_hit) && (w_press != r_held[w_id]);
  assign w_is_dir     = ~w_id[1];
  assign w_dir_press  = w_key_push && w_is_dir && w_press;
  assign w_trk_rel    = w_key_push && w_is_dir && !w_press &&
                        (r_state != S_IDLE) && (w_id[0] == r_trk);
  assign w_other_held = r_held[{1'b0, ~r_trk}];
  assign w_expire     = (r_state != S_IDLE) && (r_cnt == '0);
  // A key event takes the single push slot; the repeat for that cycle is lost.
  assign w_rpt_push   = w_expire && !w_key_push;
  assign w_push       = w_key_push || w_rpt_push;
  assign w_push_data  = w_key_push ? {1'b0, w_press, w_id} : {2'b11, 1'b0, r_trk};

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && evt_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held <= '0;
    end else if (w_key_push) begin
      r_held[w_id] <= w_press;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_trk   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_dir_press) begin
      r_state <= S_DELAY;
      r_trk   <= w_id[0];
      r_cnt   <= C_DELAY;
    end else if (w_trk_rel) begin
      if (w_other_held) begin
        r_state <= S_DELAY;
        r_trk   <= ~r_trk;
        r_cnt   <= C_DELAY;
      end else begin
        r_state <= S_IDLE;
      end
    end else if (r_state != S_IDLE) begin
      if (w_expire) begin
        r_state <= S_REPEAT;
        r_cnt   <= C_PERIOD;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_wr_en) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign evt_valid = !w_empty;
  assign evt_data  = w_empty ? 4'h0 : r_mem[r_rd_ptr[AW-1:0]];
  assign move_dir  = (r_state == S_IDLE) ? 2'b00 : (r_trk ? 2'b10 : 2'b01);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler: a vector table for single-cycle
// behaviour plus hand-written sequences for repeat timing and reset.
module tb_key_event_scheduler;

  localparam logic [8:0] K_LEFT  = 9'h16B;
  localparam logic [8:0] K_RIGHT = 9'h174;
  localparam logic [8:0] K_PAUSE = 9'h029;
  localparam logic [8:0] K_START = 9'h05A;
  localparam logic [8:0] K_OTHER = 9'h01C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [8:0]   last_change = '0;
  logic [511:0] key_down = '0;
  logic         evt_valid;
  logic [3:0]   evt_data;
  logic         evt_ready = 1'b0;
  logic [1:0]   move_dir;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  key_event_scheduler #(
    .FIFO_DEPTH(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(4),
    .KEY_LEFT(K_LEFT),
    .KEY_RIGHT(K_RIGHT),
    .KEY_PAUSE(K_PAUSE),
    .KEY_START(K_START)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_valid(key_valid),
    .last_change(last_change),
    .key_down(key_down),
    .evt_valid(evt_valid),
    .evt_data(evt_data),
    .evt_ready(evt_ready),
    .move_dir(move_dir),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         kv;
    logic [8:0] code;
    bit         dn;
    bit         rdy;
    bit         ev;
    logic [3:0] ed;
    logic [1:0] md;
    bit         ov;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check(input string name, input bit ev, input logic [3:0] ed,
                       input logic [1:0] md, input bit ov);
    cmp({name, " evt_valid"}, {3'b0, evt_valid}, {3'b0, ev});
    if (ev) cmp({name, " evt_data"}, evt_data, ed);
    cmp({name, " move_dir"}, {2'b0, move_dir}, {2'b0, md});
    cmp({name, " overflow"}, {3'b0, overflow}, {3'b0, ov});
    $display("%s: valid=%0d data=%b dir=%b ovf=%0d", name, evt_valid, evt_data, move_dir, overflow);
  endtask

  // Inputs are changed #1 after a rising edge; the call returns #1 after the next edge.
  task automatic drive(input bit kv, input logic [8:0] code, input bit dn, input bit rdy);
    key_valid   = kv;
    last_change = code;
    if (kv) key_down[code] = dn;
    evt_ready   = rdy;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 1'b0, 4'h0, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Press and release left before the repeat delay.
    vecs.push_back('{1, K_LEFT,  1, 1, 1, 4'b0100, 2'b01, 0});
    vecs.push_back('{0, K_LEFT,  0, 1, 0, 4'b0000, 2'b01, 0});
    vecs.push_back('{1, K_LEFT,  0, 1, 1, 4'b0000, 2'b00, 0});
    vecs.push_back('{0, K_LEFT,  0, 1, 0, 4'b0000, 2'b00, 0});
    vecs.push_back('{0, K_LEFT,  0, 1, 0, 4'b0000, 2'b00, 0});
    vecs.push_back('{0, K_LEFT,  0, 1, 0, 4'b0000, 2'b00, 0});
    // Typematic re-strobe and an unmapped code.
    vecs.push_back('{1, K_LEFT,  1, 1, 1, 4'b0100, 2'b01, 0});
    vecs.push_back('{1, K_LEFT,  1, 1, 0, 4'b0000, 2'b01, 0});
    vecs.push_back('{1, K_OTHER, 1, 1, 0, 4'b0000, 2'b01, 0});
    vecs.push_back('{1, K_LEFT,  0, 1, 1, 4'b0000, 2'b00, 0});
    vecs.push_back('{0, K_LEFT,  0, 1, 0, 4'b0000, 2'b00, 0});
    // Fill with consumer stalled, overflow, then pop+push while full.
    vecs.push_back('{1, K_PAUSE, 1, 0, 1, 4'b0110, 2'b00, 0});
    vecs.push_back('{1, K_PAUSE, 0, 0, 1, 4'b0110, 2'b00, 0});
    vecs.push_back('{1, K_START, 1, 0, 1, 4'b0110, 2'b00, 0});
    vecs.push_back('{1, K_START, 0, 0, 1, 4'b0110, 2'b00, 0});
    vecs.push_back('{1, K_PAUSE, 1, 0, 1, 4'b0110, 2'b00, 1});
    vecs.push_back('{1, K_PAUSE, 0, 0, 1, 4'b0110, 2'b00, 1});
    vecs.push_back('{1, K_START, 1, 1, 1, 4'b0010, 2'b00, 1});
    vecs.push_back('{0, K_START, 0, 1, 1, 4'b0111, 2'b00, 1});
    vecs.push_back('{0, K_START, 0, 1, 1, 4'b0011, 2'b00, 1});
    vecs.push_back('{0, K_START, 0, 1, 1, 4'b0111, 2'b00, 1});
    vecs.push_back('{0, K_START, 0, 1, 0, 4'b0000, 2'b00, 1});

    #3;
    check("reset_async", 1'b0, 4'h0, 2'b00, 1'b0);
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].kv, vecs[i].code, vecs[i].dn, vecs[i].rdy);
      check($sformatf("vec[%0d]", i), vecs[i].ev, vecs[i].ed, vecs[i].md, vecs[i].ov);
    end

    do_reset();

    // Hold right: repeats at press+8, +12, +16, then release.
    drive(1, K_RIGHT, 1, 1);
    check("hold_r press", 1'b1, 4'b0101, 2'b10, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      bit exp_v;
      exp_v = (c == 8) || (c == 12) || (c == 16);
      drive(0, K_RIGHT, 0, 1);
      check($sformatf("hold_r +%0d", c), exp_v, 4'b1101, 2'b10, 1'b0);
    end
    drive(1, K_RIGHT, 0, 1);
    check("hold_r release", 1'b1, 4'b0001, 2'b00, 1'b0);
    drive(0, K_RIGHT, 0, 1);
    check("hold_r drain", 1'b0, 4'h0, 2'b00, 1'b0);

    // Hold left, press and release right; left repeat delay restarts.
    drive(1, K_LEFT, 1, 1);
    check("lr left press", 1'b1, 4'b0100, 2'b01, 1'b0);
    drive(0, K_LEFT, 0, 1);
    check("lr idle1", 1'b0, 4'h0, 2'b01, 1'b0);
    drive(0, K_LEFT, 0, 1);
    check("lr idle2", 1'b0, 4'h0, 2'b01, 1'b0);
    drive(1, K_RIGHT, 1, 1);
    check("lr right press", 1'b1, 4'b0101, 2'b10, 1'b0);
    drive(0, K_LEFT, 0, 1);
    check("lr idle3", 1'b0, 4'h0, 2'b10, 1'b0);
    drive(1, K_RIGHT, 0, 1);
    check("lr right release", 1'b1, 4'b0001, 2'b01, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      drive(0, K_LEFT, 0, 1);
      check($sformatf("lr restart +%0d", c), (c == 8), 4'b1100, 2'b01, 1'b0);
    end
    drive(1, K_LEFT, 0, 1);
    check("lr left release", 1'b1, 4'b0000, 2'b00, 1'b0);
    drive(0, K_LEFT, 0, 1);
    check("lr drain", 1'b0, 4'h0, 2'b00, 1'b0);

    // Three events queued with the FSM in REPEAT, then asynchronous reset.
    drive(1, K_RIGHT, 1, 0);
    check("rst right press", 1'b1, 4'b0101, 2'b10, 1'b0);
    drive(1, K_PAUSE, 1, 0);
    check("rst pause press", 1'b1, 4'b0101, 2'b10, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      drive(0, K_PAUSE, 0, 0);
    end
    check("rst queued", 1'b1, 4'b0101, 2'b10, 1'b0);
    rst_n = 1'b0;
    #2;
    check("rst immediate", 1'b0, 4'h0, 2'b00, 1'b0);
    cmp("rst evt_data", evt_data, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, K_RIGHT, 0, 1);
    check("rst after release", 1'b0, 4'h0, 2'b00, 1'b0);
    drive(1, K_RIGHT, 1, 1);
    check("rst fresh press", 1'b1, 4'b0101, 2'b10, 1'b0);
    drive(0, K_RIGHT, 0, 1);
    check("rst fresh drain", 1'b0, 4'h0, 2'b10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
